// File: rtl/alu_pkg.sv
// Shared definitions for the parametrised accumulator ALU: opcode encodings,
// control state encoding and opcode legality check.
package alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_CLR  = 4'b0001;
   localparam logic [3:0] OP_LOAD = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_MUL  = 4'b0110;
   localparam logic [3:0] OP_SHL  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_NAND = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NOT  = 4'b1101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Opcodes 0011, 1110 and 1111 are unassigned.
   function automatic logic is_legal(input logic [3:0] op);
      logic ok;
      case (op)
         OP_NOP, OP_CLR, OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_SHL,
         OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_NOT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier. start latches x and y; one
// partial product is accumulated per clock. done is asserted combinationally
// during the cycle whose closing edge performs the WIDTH-th iteration, with
// prod_lo / prod_hi_nz already reflecting the complete product.
module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             prod_hi_nz
);

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   w_prod_nxt;

   // Partial sum including the current multiplier bit; final product on the last iteration.
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
   assign done       = r_busy & (r_cnt == LAST);
   assign prod_lo    = w_prod_nxt[WIDTH-1:0];
   assign prod_hi_nz = |w_prod_nxt[2*WIDTH-1:WIDTH];

   // Iteration registers: load on start, shift/accumulate while busy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_mcand  <= {(2*WIDTH){1'b0}};
         r_mplier <= {WIDTH{1'b0}};
         r_prod   <= {(2*WIDTH){1'b0}};
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= {CW{1'b0}};
         r_mcand  <= {{WIDTH{1'b0}}, x};
         r_mplier <= y;
         r_prod   <= {(2*WIDTH){1'b0}};
      end else if (r_busy) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         r_cnt    <= r_cnt + CW'(1);
         r_busy   <= (r_cnt != LAST);
      end else begin
         r_busy   <= 1'b0;
      end
   end

endmodule

// File: rtl/acc_alu_param.sv
// Parametrised accumulator ALU: valid/ready operand intake, opcode decode,
// single-cycle datapath, multi-cycle MUL sequencing, flags and accumulator.
module acc_alu_param
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             err
);

   // Wide enough to hold every bit the largest shift amount can push out.
   localparam int SW = WIDTH + (1 << SHW);

   state_t            r_state, w_state_nxt;
   logic [WIDTH-1:0]  r_acc, w_acc_nxt;
   logic              r_carry, w_carry_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              r_err, w_err_nxt;
   logic              r_zero;
   logic              r_out_valid, w_fire;

   logic              w_accept;
   logic              w_mul_start;
   logic              w_mul_done;
   logic [WIDTH-1:0]  w_mul_lo;
   logic              w_mul_hi_nz;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_diff;
   logic              w_borrow;
   logic              w_add_ovf;
   logic              w_sub_ovf;
   logic [SW-1:0]     w_shl;

   assign in_ready    = (r_state == ST_IDLE);
   assign w_accept    = in_valid & in_ready;
   assign w_mul_start = w_accept & (opcode == OP_MUL);

   assign w_sum     = {1'b0, r_acc} + {1'b0, a};
   assign w_diff    = r_acc - a;
   assign w_borrow  = (r_acc < a);
   assign w_add_ovf = (r_acc[WIDTH-1] == a[WIDTH-1]) & (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
   assign w_sub_ovf = (r_acc[WIDTH-1] != a[WIDTH-1]) & (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
   assign w_shl     = {{(SW-WIDTH){1'b0}}, r_acc} << a[SHW-1:0];

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (w_mul_start),
      .x          (r_acc),
      .y          (a),
      .done       (w_mul_done),
      .prod_lo    (w_mul_lo),
      .prod_hi_nz (w_mul_hi_nz)
   );

   // Next-state, next accumulator/flags and result-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_carry_nxt = r_carry;
      w_ovf_nxt   = r_ovf;
      w_err_nxt   = r_err;
      w_fire      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_fire = 1'b1;
               if (!is_legal(opcode)) begin
                  w_err_nxt = 1'b1;
               end else begin
                  case (opcode)
                     OP_NOP:  w_acc_nxt = r_acc;
                     OP_CLR: begin
                        w_acc_nxt   = {WIDTH{1'b0}};
                        w_carry_nxt = 1'b0;
                        w_ovf_nxt   = 1'b0;
                        w_err_nxt   = 1'b0;
                     end
                     OP_LOAD: w_acc_nxt = a;
                     OP_ADD: begin
                        w_acc_nxt   = w_sum[WIDTH-1:0];
                        w_carry_nxt = w_sum[WIDTH];
                        w_ovf_nxt   = w_add_ovf;
                        w_err_nxt   = r_err | w_sum[WIDTH] | w_add_ovf;
                     end
                     OP_SUB: begin
                        w_acc_nxt   = w_diff;
                        w_carry_nxt = w_borrow;
                        w_ovf_nxt   = w_sub_ovf;
                        w_err_nxt   = r_err | w_borrow | w_sub_ovf;
                     end
                     OP_MUL: begin
                        // Result is written when the multiplier finishes.
                        w_fire      = 1'b0;
                        w_state_nxt = ST_MUL;
                     end
                     OP_SHL: begin
                        w_acc_nxt   = w_shl[WIDTH-1:0];
                        w_carry_nxt = |w_shl[SW-1:WIDTH];
                        w_err_nxt   = r_err | (|w_shl[SW-1:WIDTH]);
                     end
                     OP_AND:  w_acc_nxt = r_acc & a;
                     OP_OR:   w_acc_nxt = r_acc | a;
                     OP_XOR:  w_acc_nxt = r_acc ^ a;
                     OP_NAND: w_acc_nxt = ~(r_acc & a);
                     OP_NOR:  w_acc_nxt = ~(r_acc | a);
                     OP_NOT:  w_acc_nxt = ~r_acc;
                     default: w_err_nxt = 1'b1;
                  endcase
               end
            end else begin
               w_fire = 1'b0;
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_acc_nxt   = w_mul_lo;
               w_carry_nxt = w_mul_hi_nz;
               w_err_nxt   = r_err | w_mul_hi_nz;
               w_fire      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_MUL;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Control state, accumulator, flags and output pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_acc       <= {WIDTH{1'b0}};
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_carry     <= w_carry_nxt;
         r_ovf       <= w_ovf_nxt;
         r_err       <= w_err_nxt;
         r_zero      <= (w_acc_nxt == {WIDTH{1'b0}});
         r_out_valid <= w_fire;
      end
   end

   assign result    = r_acc;
   assign carry     = r_carry;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign err       = r_err;
   assign out_valid = r_out_valid;

endmodule

// File: doc/acc_alu_param.md
Name: acc_alu_param

Overview:
- Parametrised accumulator ALU, the next generation of the team's 16-bit accumulator ALU. Width is configurable.
- Each operation combines the registered accumulator with operand `a` through a valid/ready handshake.
- Adds LOAD, a multi-cycle shift-add multiply and a barrel shift-left, plus carry/overflow/zero flags and a sticky error flag.
- Sits between the operand/opcode source (testbench or sequencer) and any downstream result consumer.

Parameters:
- WIDTH, 16, datapath and accumulator width in bits (≥4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from a[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  opcode/operand present
- in_ready  out  1  block can accept; low while MUL is in progress
- opcode  in  4  operation select
- a  in  WIDTH  operand
- out_valid  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  accumulator value (registered)
- carry  out  1  ADD carry-out / SUB borrow / MUL unsigned overflow
- ovf  out  1  signed overflow of last ADD/SUB
- zero  out  1  result == 0
- err  out  1  sticky error; cleared only by CLR or reset

Behaviour:
- **Clock and reset.** Single clock `clk`. Reset is synchronous and active-low on `rst_n`.
  - `rst_n` low at an edge: acc=0, carry=ovf=err=0, zero=1, out_valid=0, in_ready=1; any MUL in progress is aborted.
- **Accept.** A transfer happens at edge k when in_valid & in_ready. in_valid while in_ready=0 is ignored, not queued.
- **Opcodes** (acc' is the new accumulator):
  - 0000 NOP: acc unchanged.
  - 0001 CLR: acc=0, all flags cleared, zero=1.
  - 0010 LOAD: acc=a.
  - 0100 ADD: acc=acc+a mod 2^WIDTH. carry=carry-out; ovf=signed overflow.
  - 0101 SUB: acc=acc-a. carry=borrow (acc<a unsigned); ovf=signed overflow.
  - 0110 MUL: acc=low WIDTH bits of acc*a (unsigned). carry=1 if the high half is nonzero.
  - 0111 SHL: acc=acc<<a[SHW-1:0]. carry=OR of the bits shifted out.
  - 1000 AND, 1001 OR, 1010 XOR, 1011 NAND, 1100 NOR: bitwise acc op a.
  - 1101 NOT: acc=~acc.
  - 0011, 1110, 1111 are illegal: acc unchanged, err set, out_valid still pulses.
- **Flag rules.**
  - Ops that do not define carry/ovf leave them unchanged.
  - zero always reflects the new acc.
  - err is set whenever carry is set by ADD, SUB, MUL or SHL, or ovf is set by ADD or SUB.
- **Single-cycle ops.** acc and flags update at edge k. out_valid=1 for the cycle after edge k. in_ready stays 1, so back-to-back accepts are allowed every cycle.
- **MUL state machine (IDLE→MUL→IDLE).**
  - At accept: latch a; in_ready=0 from after edge k.
  - One shift-add iteration per edge, WIDTH iterations in total.
  - At edge k+WIDTH: acc and flags written, state returns to IDLE, in_ready=1, out_valid pulses in the following cycle.
  - Latency is WIDTH+1 cycles from accept to out_valid.
  - result holds the old acc during the multiply.
- **Output timing.** out_valid is never held longer than one cycle; there is no backpressure on the output.

Decomposition:
- **Shared package `alu_pkg`:** opcode localparams (OP_NOP … OP_NOT), a state enum {ST_IDLE, ST_MUL}, and a function is_legal(opcode).
- **Sub-module `alu_mul_seq`** (WIDTH-parametrised shift-add multiplier).
  - Inputs: start, x, y.
  - Outputs: done, prod_lo, prod_hi_nz.
- **Top level:** handshake, opcode decode, single-cycle datapath, flags and accumulator register.

Test Plan (WIDTH=16):
- Reset, then ADD 35000 twice → result 35000, then 4464; on the second op carry=1, err=1, out_valid one pulse per op.
- CLR, ADD 4, SUB 3 → result 1, carry=0; then SUB 2 → result 0xFFFF, carry=1, zero=0.
- LOAD 300, MUL 300 → in_ready=0 for 16 cycles; out_valid 17 cycles after accept; result 24464, carry=1, err=1. An in_valid pulse issued during the busy period is ignored.
- LOAD 0xFFFF, XOR 0x00FF, NOR 0x000F, NOT, issued back-to-back → results 0xFFFF, 0xFF00, 0x00F0, 0xFF0F on consecutive cycles.
- Opcode 1111 with acc=0x1234 → result stays 0x1234, err=1, out_valid pulses; a following CLR → err=0, zero=1.
- rst_n low for one edge mid-MUL (iteration 5) → next cycle result=0, in_ready=1, out_valid=0; no late out_valid.
